// File: rtl/m6502_intc_pkg.sv
// rtl/m6502_intc_pkg.sv - shared constants and NMI state encoding for m6502_intc
package m6502_intc_pkg;

  localparam logic [1:0] OFS_PEND = 2'd0;
  localparam logic [1:0] OFS_MASK = 2'd1;
  localparam logic [1:0] OFS_EDGE = 2'd2;
  localparam logic [1:0] OFS_VEC  = 2'd3;

  localparam logic [15:0] VEC_NMI = 16'hFFFA;
  localparam logic [15:0] VEC_IRQ = 16'hFFFE;

  localparam logic [7:0] VEC_NONE = 8'h80;

  typedef enum logic [1:0] {
    NMI_IDLE    = 2'd0,
    NMI_ASSERT  = 2'd1,
    NMI_HOLDOFF = 2'd2
  } nmi_state_t;

endpackage

// File: rtl/prio_enc8.sv
// rtl/prio_enc8.sv - 8-bit priority encoder, lowest set index wins
module prio_enc8 (
  input  logic [7:0] req,
  output logic [2:0] idx,
  output logic       none
);

  // Scan from the top down so the lowest set bit is the last assignment.
  always_comb begin
    idx  = 3'd0;
    none = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      if (req[i]) begin
        idx  = 3'(i);
        none = 1'b0;
      end
    end
  end

endmodule

// File: rtl/m6502_intc.sv
// rtl/m6502_intc.sv - 8-source IRQ plus NMI interrupt controller feeding the 6502 core
import m6502_intc_pkg::*;

module m6502_intc #(
  parameter logic [15:0] BASE = 16'hFF00,
  parameter int          NSRC = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] addr,
  input  logic [7:0]  datao,
  input  logic        we_n,
  input  logic        vpa,
  input  logic [7:0]  irq_src,
  input  logic        nmi_src,
  output logic [7:0]  dout,
  output logic        dout_en,
  output logic        irq_n,
  output logic        nmi_n
);

  localparam logic [7:0] IMPL = 8'((9'd1 << NSRC) - 9'd1);

  logic [7:0]  pend, mask, edge_mode, vec, src_d;
  logic [7:0]  rise, clr, pend_nxt, active;
  logic [15:0] ofs;
  logic [1:0]  reg_ofs;
  logic        in_range, wr_en, irq_fetch, nmi_ack;
  logic [2:0]  act_idx;
  logic        act_none;

  logic       nmi_d, nmi_rise, nmi_mem, nmi_mem_nxt;
  nmi_state_t state, state_nxt;

  assign ofs       = addr - BASE;
  assign in_range  = (ofs[15:2] == 14'd0);
  assign reg_ofs   = ofs[1:0];
  assign wr_en     = in_range & ~we_n;
  assign dout_en   = in_range & we_n;
  assign irq_fetch = vpa & we_n & (addr == VEC_IRQ);
  assign nmi_ack   = vpa & we_n & (addr == VEC_NMI);

  always_comb begin
    dout = 8'h00;
    if (dout_en) begin
      case (reg_ofs)
        OFS_PEND: dout = pend;
        OFS_MASK: dout = mask;
        OFS_EDGE: dout = edge_mode;
        default:  dout = vec;
      endcase
    end
  end

  assign rise   = irq_src & ~src_d & IMPL;
  assign clr    = (wr_en && reg_ofs == OFS_PEND) ? datao : 8'h00;
  // Set beats clear in edge mode; level mode just tracks the source.
  assign pend_nxt = IMPL & ((edge_mode & (rise | (pend & ~clr))) |
                            (~edge_mode & irq_src));
  assign active = pend & mask;

  prio_enc8 u_prio (
    .req  (active),
    .idx  (act_idx),
    .none (act_none)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      pend      <= 8'h00;
      mask      <= 8'h00;
      edge_mode <= 8'h00;
      vec       <= VEC_NONE;
      src_d     <= 8'h00;
      irq_n     <= 1'b1;
    end else begin
      src_d <= irq_src & IMPL;
      pend  <= pend_nxt;
      irq_n <= ~|active;
      if (wr_en && reg_ofs == OFS_MASK) mask <= datao & IMPL;
      if (wr_en && reg_ofs == OFS_EDGE) edge_mode <= datao & IMPL;
      if (irq_fetch) vec <= act_none ? VEC_NONE : {5'd0, act_idx};
    end
  end

  assign nmi_rise = nmi_src & ~nmi_d;

  // nmi_mem carries a rise seen at ack time so it re-asserts after the holdoff cycle.
  always_comb begin
    state_nxt   = state;
    nmi_mem_nxt = nmi_mem;
    case (state)
      NMI_IDLE: begin
        if (nmi_rise) state_nxt = NMI_ASSERT;
      end
      NMI_ASSERT: begin
        if (nmi_ack) begin
          state_nxt   = NMI_HOLDOFF;
          nmi_mem_nxt = nmi_rise;
        end
      end
      NMI_HOLDOFF: begin
        state_nxt   = (nmi_mem | nmi_rise) ? NMI_ASSERT : NMI_IDLE;
        nmi_mem_nxt = 1'b0;
      end
      default: begin
        state_nxt   = NMI_IDLE;
        nmi_mem_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= NMI_IDLE;
      nmi_mem <= 1'b0;
      nmi_d   <= 1'b0;
      nmi_n   <= 1'b1;
    end else begin
      state   <= state_nxt;
      nmi_mem <= nmi_mem_nxt;
      nmi_d   <= nmi_src;
      nmi_n   <= ~(state_nxt == NMI_ASSERT);
    end
  end

endmodule

// File: tb/tb_m6502_intc.sv
// tb/tb_m6502_intc.sv - scoreboard bench for m6502_intc
module tb_m6502_intc;

  localparam int S_DOUT = 0;
  localparam int S_DEN  = 1;
  localparam int S_IRQN = 2;
  localparam int S_NMIN = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] addr;
  logic [7:0]  datao;
  logic        we_n, vpa, nmi_src;
  logic [7:0]  irq_src;
  logic [7:0]  dout;
  logic        dout_en, irq_n, nmi_n;

  m6502_intc dut (
    .clk     (clk),
    .reset   (reset),
    .addr    (addr),
    .datao   (datao),
    .we_n    (we_n),
    .vpa     (vpa),
    .irq_src (irq_src),
    .nmi_src (nmi_src),
    .dout    (dout),
    .dout_en (dout_en),
    .irq_n   (irq_n),
    .nmi_n   (nmi_n)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    int         sig;
    logic [7:0] exp;
    string      name;
  } exp_t;

  exp_t       q[$];
  exp_t       mx;
  int         cyc = 0;
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] act;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] sample(input int sig);
    case (sig)
      S_DOUT:  return dout;
      S_DEN:   return {7'd0, dout_en};
      S_IRQN:  return {7'd0, irq_n};
      default: return {7'd0, nmi_n};
    endcase
  endfunction

  // Monitor: pops every expectation due this cycle and compares mid-cycle.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      mx  = q.pop_front();
      act = sample(mx.sig);
      n_cmp++;
      if (mx.cyc != cyc || act !== mx.exp) begin
        n_bad++;
        $display("FAIL %s: got %h expected %h (cycle %0d)", mx.name, act, mx.exp, cyc);
      end
    end
  end

  task automatic chk(input int sig, input logic [7:0] e, input string n);
    exp_t x;
    x.cyc = cyc; x.sig = sig; x.exp = e; x.name = n;
    q.push_back(x);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [15:0] a, input logic [7:0] e, input string n);
    addr = a; we_n = 1'b1; vpa = 1'b0;
    chk(S_DOUT, e, n);
    chk(S_DEN, 8'd1, {n, "_en"});
    tick();
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    addr = a; datao = d; we_n = 1'b0;
    tick();
    we_n = 1'b1; addr = 16'h0000; datao = 8'h00;
  endtask

  task automatic vfetch(input logic [15:0] a);
    addr = a; vpa = 1'b1; we_n = 1'b1;
    chk(S_DEN, 8'd0, "vfetch_no_en");
    tick();
    vpa = 1'b0; addr = 16'h0000;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; addr = 16'h0000; datao = 8'h00; we_n = 1'b1; vpa = 1'b0;
    irq_src = 8'h00; nmi_src = 1'b0;
    tick(); tick();
    reset = 1'b0;

    chk(S_IRQN, 8'd1, "rst_irq_n");
    chk(S_NMIN, 8'd1, "rst_nmi_n");
    rd(16'hFF00, 8'h00, "rst_pend");
    rd(16'hFF01, 8'h00, "rst_mask");
    rd(16'hFF02, 8'h00, "rst_edge");
    rd(16'hFF03, 8'h80, "rst_vec");
    addr = 16'hFF04;
    chk(S_DEN, 8'd0, "oor_hi_en"); chk(S_DOUT, 8'h00, "oor_hi_dout");
    tick();
    addr = 16'hFEFF;
    chk(S_DEN, 8'd0, "oor_lo_en"); chk(S_DOUT, 8'h00, "oor_lo_dout");
    tick();
    addr = 16'hFF02; we_n = 1'b0;
    chk(S_DEN, 8'd0, "write_no_en");
    tick();
    we_n = 1'b1;

    // Edge-mode source 2
    wr(16'hFF01, 8'h0C);
    wr(16'hFF02, 8'h04);
    irq_src = 8'h04;
    tick();
    irq_src = 8'h00;
    chk(S_IRQN, 8'd1, "edge_irq_n_1cyc");
    rd(16'hFF00, 8'h04, "edge_pend");
    chk(S_IRQN, 8'd0, "edge_irq_n_low");
    wr(16'hFF00, 8'h04);
    chk(S_IRQN, 8'd0, "w1c_irq_n_lag");
    tick();
    chk(S_IRQN, 8'd1, "w1c_irq_n_high");
    rd(16'hFF00, 8'h00, "w1c_pend");

    // Level-mode source 3
    irq_src = 8'h08;
    tick(); tick();
    chk(S_IRQN, 8'd0, "lvl_irq_n_low");
    wr(16'hFF00, 8'h08);
    chk(S_IRQN, 8'd0, "lvl_w1c_irq_n");
    rd(16'hFF00, 8'h08, "lvl_w1c_pend");
    irq_src = 8'h00;
    tick();
    chk(S_IRQN, 8'd0, "lvl_drop_lag");
    rd(16'hFF00, 8'h00, "lvl_drop_pend");
    chk(S_IRQN, 8'd1, "lvl_drop_irq_n");
    tick();

    // Vector snapshot
    wr(16'hFF01, 8'h23);
    irq_src = 8'h22;
    tick();
    vfetch(16'hFFFE);
    rd(16'hFF03, 8'h01, "vec_idx1");
    irq_src = 8'h23;
    tick(); tick();
    rd(16'hFF03, 8'h01, "vec_held");
    rd(16'hFF00, 8'h23, "vec_pend");
    vfetch(16'hFFFE);
    rd(16'hFF03, 8'h00, "vec_idx0");
    irq_src = 8'h00;
    tick();
    vfetch(16'hFFFE);
    rd(16'hFF03, 8'h80, "vec_none");
    wr(16'hFF03, 8'h55);
    rd(16'hFF03, 8'h80, "vec_ro");

    // NMI sequencing
    nmi_src = 1'b1;
    chk(S_NMIN, 8'd1, "nmi_pre");
    tick();
    chk(S_NMIN, 8'd0, "nmi_assert");
    nmi_src = 1'b0;
    tick();
    chk(S_NMIN, 8'd0, "nmi_hold");
    vfetch(16'hFFFA);
    chk(S_NMIN, 8'd1, "nmi_holdoff");
    nmi_src = 1'b1;
    tick();
    chk(S_NMIN, 8'd0, "nmi_rearm");
    nmi_src = 1'b0;
    vfetch(16'hFFFA);
    chk(S_NMIN, 8'd1, "nmi_holdoff2");
    tick();
    chk(S_NMIN, 8'd1, "nmi_idle");
    tick();
    chk(S_NMIN, 8'd1, "nmi_idle2");
    nmi_src = 1'b1;
    tick();
    nmi_src = 1'b0;
    chk(S_NMIN, 8'd0, "nmi_assert3");
    tick();
    nmi_src = 1'b1;
    vfetch(16'hFFFA);
    chk(S_NMIN, 8'd1, "nmi_ack_rise_hold");
    tick();
    chk(S_NMIN, 8'd0, "nmi_ack_rise_mem");
    nmi_src = 1'b0;
    tick();
    chk(S_NMIN, 8'd0, "nmi_still_assert");

    // Set beats W1C, then reset mid-operation
    wr(16'hFF02, 8'h04);
    irq_src = 8'h04; addr = 16'hFF00; datao = 8'h04; we_n = 1'b0;
    tick();
    irq_src = 8'h00; we_n = 1'b1; datao = 8'h00;
    rd(16'hFF00, 8'h04, "set_wins");
    chk(S_NMIN, 8'd0, "pre_reset_nmi");
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk(S_NMIN, 8'd1, "reset_nmi_n");
    chk(S_IRQN, 8'd1, "reset_irq_n");
    rd(16'hFF00, 8'h00, "reset_pend");
    rd(16'hFF01, 8'h00, "reset_mask");
    rd(16'hFF02, 8'h00, "reset_edge");
    rd(16'hFF03, 8'h80, "reset_vec");

    tick(); tick();
    if (q.size() != 0) begin
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
      n_cmp += q.size();
      n_bad += q.size();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
